// File: rtl/bsg_fifo_rolly_replay_tx.sv
// bsg_fifo_rolly_replay_tx
//   Go-back-N link transmitter on the read side of a rollback (rolly) FIFO.
//   Words are dequeued onto the link and remain in the FIFO until the far
//   end acknowledges them (single or cumulative). A nack or a response
//   timeout rewinds the FIFO read pointer to its checkpoint so that every
//   unacknowledged word is re-sent. Too many rollbacks without progress
//   park the block in a sticky ERROR state.
//
// Ports
//   clk_i, reset_n_i          clock, async active-low reset
//   fifo_data_i/fifo_v_i      FIFO read data / valid
//   fifo_yumi_o               dequeue strobe (advances FIFO rptr)
//   fifo_incr_o               advance FIFO checkpoint by one word
//   fifo_ack_o                advance FIFO checkpoint to rptr
//   fifo_rollback_o           rewind FIFO rptr to checkpoint
//   link_data_o/link_v_o      word and valid to the link
//   link_ready_i              link ready
//   resp_v_i/resp_type_i      response: 0 single ack, 1 cumulative ack,
//                             2 nack, 3 reserved
//   outstanding_o             unacknowledged word count
//   error_o                   sticky retry-exhaustion flag
//   proto_err_o               one-cycle pulse on an illegal response
module bsg_fifo_rolly_replay_tx #(
  parameter int width_p       = 8,
  parameter int lg_size_p     = 3,
  parameter int window_p      = (1 << lg_size_p),
  parameter int timeout_p     = 64,
  parameter int max_retries_p = 8
) (
  input  logic                 clk_i,
  input  logic                 reset_n_i,
  input  logic [width_p-1:0]   fifo_data_i,
  input  logic                 fifo_v_i,
  output logic                 fifo_yumi_o,
  output logic                 fifo_incr_o,
  output logic                 fifo_ack_o,
  output logic                 fifo_rollback_o,
  output logic [width_p-1:0]   link_data_o,
  output logic                 link_v_o,
  input  logic                 link_ready_i,
  input  logic                 resp_v_i,
  input  logic [1:0]           resp_type_i,
  output logic [lg_size_p:0]   outstanding_o,
  output logic                 error_o,
  output logic                 proto_err_o
);

  localparam int cnt_w = lg_size_p + 1;
  localparam int tmr_w = $clog2(timeout_p + 1);
  localparam int rty_w = $clog2(max_retries_p + 1);

  localparam logic [cnt_w-1:0] window_lp      = cnt_w'(window_p);
  localparam logic [tmr_w-1:0] timeout_lp     = tmr_w'(timeout_p);
  localparam logic [rty_w-1:0] max_retries_lp = rty_w'(max_retries_p);

  typedef enum logic {ST_SEND, ST_ERROR} state_e;

  state_e             state_q, state_d;
  logic [cnt_w-1:0]   outstanding_q, outstanding_d;
  logic [tmr_w-1:0]   timer_q, timer_d;
  logic [rty_w-1:0]   retry_q, retry_d;

  logic link_v, yumi, incr, ack, rollback, proto_err;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q       <= ST_SEND;
      outstanding_q <= '0;
      timer_q       <= '0;
      retry_q       <= '0;
    end else begin
      state_q       <= state_d;
      outstanding_q <= outstanding_d;
      timer_q       <= timer_d;
      retry_q       <= retry_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    outstanding_d = outstanding_q;
    timer_d       = timer_q;
    retry_d       = retry_q;
    link_v        = 1'b0;
    yumi          = 1'b0;
    incr          = 1'b0;
    ack           = 1'b0;
    rollback      = 1'b0;
    proto_err     = 1'b0;

    // Combinational outputs are gated by reset so every output reads 0
    // while reset is held, independent of what the FIFO presents.
    if (reset_n_i && state_q == ST_SEND) begin
      // At most one FIFO checkpoint control per cycle; a response always
      // wins over a coincident timeout.
      if (resp_v_i) begin
        unique case (resp_type_i)
          2'b00: begin
            if (outstanding_q != '0) incr      = 1'b1;
            else                     proto_err = 1'b1;
          end
          2'b01:   ack       = 1'b1;
          2'b10:   rollback  = 1'b1;
          default: proto_err = 1'b1;
        endcase
      end else if (outstanding_q != '0 && timer_q == timeout_lp) begin
        rollback = 1'b1;
      end

      // Valid drops in a rollback cycle: the FIFO rptr is rewinding, so the
      // presented word is not the one that will be re-sent first.
      link_v = fifo_v_i && (outstanding_q < window_lp) && !rollback;
      yumi   = link_v && link_ready_i;

      if (rollback)  outstanding_d = '0;
      else if (ack)  outstanding_d = cnt_w'(yumi);
      else           outstanding_d = outstanding_q + cnt_w'(yumi) - cnt_w'(incr);

      // Timer counts full response-free cycles with words in flight; the
      // cycle that clears it is not counted.
      if (incr || ack || rollback || outstanding_q == '0) timer_d = '0;
      else if (timer_q != timeout_lp)                      timer_d = timer_q + tmr_w'(1);

      if (incr || ack) begin
        retry_d = '0;
      end else if (rollback) begin
        retry_d = retry_q + rty_w'(1);
        if (retry_d == max_retries_lp) state_d = ST_ERROR;
      end
    end
  end

  assign link_data_o     = fifo_data_i;
  assign link_v_o        = link_v;
  assign fifo_yumi_o     = yumi;
  assign fifo_incr_o     = incr;
  assign fifo_ack_o      = ack;
  assign fifo_rollback_o = rollback;
  assign proto_err_o     = proto_err;
  assign outstanding_o   = outstanding_q;
  assign error_o         = (state_q == ST_ERROR);

endmodule

// File: tb/tb_bsg_fifo_rolly_replay_tx.sv
// Bench for bsg_fifo_rolly_replay_tx: a rolly-FIFO model feeds the DUT,
// table vectors cover the directed scenarios, then random traffic is checked
// cycle by cycle against a counter-level reference model.
module tb_bsg_fifo_rolly_replay_tx;
  localparam int W = 16, LG = 3, WIN = 4, TO = 4, MR = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset_n_i;
  logic [W-1:0]  fifo_data_i, link_data_o;
  logic          fifo_v_i, fifo_yumi_o, fifo_incr_o, fifo_ack_o, fifo_rollback_o;
  logic          link_v_o, link_ready_i, resp_v_i, error_o, proto_err_o;
  logic [1:0]    resp_type_i;
  logic [LG:0]   outstanding_o;

  bsg_fifo_rolly_replay_tx #(.width_p(W), .lg_size_p(LG), .window_p(WIN),
    .timeout_p(TO), .max_retries_p(MR)) dut (
    .clk_i(clk), .reset_n_i(reset_n_i),
    .fifo_data_i(fifo_data_i), .fifo_v_i(fifo_v_i), .fifo_yumi_o(fifo_yumi_o),
    .fifo_incr_o(fifo_incr_o), .fifo_ack_o(fifo_ack_o),
    .fifo_rollback_o(fifo_rollback_o), .link_data_o(link_data_o),
    .link_v_o(link_v_o), .link_ready_i(link_ready_i), .resp_v_i(resp_v_i),
    .resp_type_i(resp_type_i), .outstanding_o(outstanding_o),
    .error_o(error_o), .proto_err_o(proto_err_o));

  int vecs = 0, errs = 0;
  int rptr, cptr, wptr;                 // rolly FIFO model pointers
  int m_out, m_tmr, m_rty; bit m_err;   // reference model

  function automatic logic [W-1:0] word(int i);
    return W'(4096 + 3 * i);
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic logic [10:0] outs();
    return {link_v_o, fifo_yumi_o, fifo_incr_o, fifo_ack_o, fifo_rollback_o,
            proto_err_o, error_o, outstanding_o};
  endfunction

  // Called at a negedge; returns at the following negedge.
  task automatic reset_load(int n);
    reset_n_i = 1'b0; fifo_v_i = 1'b1; fifo_data_i = word(0);
    link_ready_i = 1'b1; resp_v_i = 1'b1; resp_type_i = 2'd2;
    #2 check("reset_outs", 32'(outs()), 32'd0);
    @(posedge clk); @(negedge clk);
    fifo_v_i = 1'b0; resp_v_i = 1'b0; resp_type_i = 2'd0; link_ready_i = 1'b0;
    rptr = 0; cptr = 0; wptr = n;
    m_out = 0; m_tmr = 0; m_rty = 0; m_err = 0;
    reset_n_i = 1'b1;
  endtask

  // One clock cycle: drive, check against the model, advance FIFO and model.
  task automatic cyc(bit fv_en, bit rdy, bit rv, logic [1:0] rt,
                     output logic [10:0] obs, output logic [W-1:0] od);
    bit e_rb, e_inc, e_ack, e_pe, e_lv, e_y, fv;
    int nxt;
    fv = fv_en && (rptr < wptr);
    fifo_v_i = fv; fifo_data_i = word(rptr);
    link_ready_i = rdy; resp_v_i = rv; resp_type_i = rt;
    #2;
    obs = outs(); od = link_data_o;
    e_rb  = !m_err && ((rv && rt == 2) || (!rv && m_out != 0 && m_tmr == TO));
    e_inc = !m_err && rv && rt == 0 && m_out > 0;
    e_ack = !m_err && rv && rt == 1;
    e_pe  = !m_err && rv && (rt == 3 || (rt == 0 && m_out == 0));
    e_lv  = !m_err && fv && m_out < WIN && !e_rb;
    e_y   = e_lv && rdy;
    check("model_outs", 32'(obs),
          32'({e_lv, e_y, e_inc, e_ack, e_rb, e_pe, m_err, 4'(m_out)}));
    if (e_lv) check("model_data", 32'(od), 32'(word(rptr)));
    check("inv_ack_excl", 32'(fifo_ack_o && (fifo_incr_o || fifo_rollback_o)), 0);
    check("inv_incr_zero", 32'(fifo_incr_o && outstanding_o == 0), 0);
    check("inv_yumi_rb", 32'(fifo_yumi_o && fifo_rollback_o), 0);
    check("inv_window", 32'(outstanding_o > WIN), 0);
    @(posedge clk);
    // FIFO reacts to what the DUT actually drove
    begin
      int r0 = rptr;
      if (obs[6]) rptr = cptr;
      if (obs[9]) rptr = rptr + 1;
      if (obs[7]) cptr = r0;
      if (obs[8]) cptr = cptr + 1;
    end
    nxt = e_rb ? 0 : e_ack ? int'(e_y) : m_out + int'(e_y) - int'(e_inc);
    m_tmr = (e_inc || e_ack || e_rb || m_out == 0) ? 0 : (m_tmr < TO ? m_tmr + 1 : TO);
    if (e_inc || e_ack) m_rty = 0;
    else if (e_rb) begin m_rty++; if (m_rty == MR) m_err = 1; end
    m_out = nxt;
    @(negedge clk);
  endtask

  typedef struct {
    int op; int n;
    bit fv, rdy, rv; logic [1:0] rt;
    bit lv, y, inc, ack, rb, pe, er; int out; int wd;
  } vec_t;

  function automatic vec_t R(int n);
    vec_t v; v = '{default: 0}; v.op = 1; v.n = n; return v;
  endfunction

  function automatic vec_t C(bit fv, bit rdy, bit rv, logic [1:0] rt,
    bit lv, bit y, bit inc, bit ack, bit rb, bit pe, bit er, int out, int wd);
    vec_t v;
    v = '{op: 0, n: 0, fv: fv, rdy: rdy, rv: rv, rt: rt, lv: lv, y: y,
          inc: inc, ack: ack, rb: rb, pe: pe, er: er, out: out, wd: wd};
    return v;
  endfunction

  vec_t tbl[$];
  logic [10:0] obs;
  logic [W-1:0] od;

  initial begin
    reset_n_i = 1'b0; fifo_v_i = 1'b0; fifo_data_i = '0; link_ready_i = 1'b0;
    resp_v_i = 1'b0; resp_type_i = 2'd0;
    // window stall, single ack at full, cumulative ack with send
    tbl.push_back(R(6));
    tbl.push_back(C(1,1,0,0, 1,1,0,0,0,0,0, 0,0));
    tbl.push_back(C(1,1,0,0, 1,1,0,0,0,0,0, 1,1));
    tbl.push_back(C(1,1,0,0, 1,1,0,0,0,0,0, 2,2));
    tbl.push_back(C(1,1,0,0, 1,1,0,0,0,0,0, 3,3));
    tbl.push_back(C(1,1,0,0, 0,0,0,0,0,0,0, 4,0));
    tbl.push_back(C(1,1,1,0, 0,0,1,0,0,0,0, 4,0));
    tbl.push_back(C(1,1,1,1, 1,1,0,1,0,0,0, 3,4));
    tbl.push_back(C(1,1,0,0, 1,1,0,0,0,0,0, 1,5));
    tbl.push_back(C(1,1,0,0, 0,0,0,0,0,0,0, 2,0));
    // nack rewind with 3 outstanding
    tbl.push_back(R(5));
    tbl.push_back(C(1,1,0,0, 1,1,0,0,0,0,0, 0,0));
    tbl.push_back(C(1,1,0,0, 1,1,0,0,0,0,0, 1,1));
    tbl.push_back(C(1,1,0,0, 1,1,0,0,0,0,0, 2,2));
    tbl.push_back(C(1,1,1,2, 0,0,0,0,1,0,0, 3,0));
    tbl.push_back(C(1,1,0,0, 1,1,0,0,0,0,0, 0,0));
    tbl.push_back(C(1,1,0,0, 1,1,0,0,0,0,0, 1,1));
    // timeout rollbacks then retry exhaustion
    tbl.push_back(R(3));
    tbl.push_back(C(1,1,0,0, 1,1,0,0,0,0,0, 0,0));
    tbl.push_back(C(1,1,0,0, 1,1,0,0,0,0,0, 1,1));
    tbl.push_back(C(1,1,0,0, 1,1,0,0,0,0,0, 2,2));
    tbl.push_back(C(1,1,0,0, 0,0,0,0,0,0,0, 3,0));
    tbl.push_back(C(1,1,0,0, 0,0,0,0,0,0,0, 3,0));
    tbl.push_back(C(1,1,0,0, 0,0,0,0,1,0,0, 3,0));
    tbl.push_back(C(1,1,0,0, 1,1,0,0,0,0,0, 0,0));
    tbl.push_back(C(1,1,0,0, 1,1,0,0,0,0,0, 1,1));
    tbl.push_back(C(1,1,0,0, 1,1,0,0,0,0,0, 2,2));
    tbl.push_back(C(1,1,0,0, 0,0,0,0,0,0,0, 3,0));
    tbl.push_back(C(1,1,0,0, 0,0,0,0,0,0,0, 3,0));
    tbl.push_back(C(1,1,0,0, 0,0,0,0,1,0,0, 3,0));
    tbl.push_back(C(1,1,0,0, 0,0,0,0,0,0,1, 0,0));
    tbl.push_back(C(1,1,1,2, 0,0,0,0,0,0,1, 0,0));
    // protocol errors leave state untouched
    tbl.push_back(R(2));
    tbl.push_back(C(0,1,1,0, 0,0,0,0,0,1,0, 0,0));
    tbl.push_back(C(0,1,1,3, 0,0,0,0,0,1,0, 0,0));
    tbl.push_back(C(1,1,0,0, 1,1,0,0,0,0,0, 0,0));
    tbl.push_back(C(0,1,1,3, 0,0,0,0,0,1,0, 1,0));
    tbl.push_back(C(0,1,0,0, 0,0,0,0,0,0,0, 1,0));

    @(negedge clk);
    foreach (tbl[i]) begin
      if (tbl[i].op == 1) reset_load(tbl[i].n);
      else begin
        cyc(tbl[i].fv, tbl[i].rdy, tbl[i].rv, tbl[i].rt, obs, od);
        check($sformatf("tbl[%0d]", i), 32'(obs),
              32'({tbl[i].lv, tbl[i].y, tbl[i].inc, tbl[i].ack, tbl[i].rb,
                   tbl[i].pe, tbl[i].er, 4'(tbl[i].out)}));
        if (tbl[i].lv) check($sformatf("tbl[%0d].data", i), 32'(od), 32'(word(tbl[i].wd)));
      end
    end

    // reset asserted mid-burst clears outputs immediately
    reset_load(6);
    cyc(1, 1, 0, 0, obs, od);
    cyc(1, 1, 0, 0, obs, od);
    fifo_v_i = 1'b1; link_ready_i = 1'b1;
    #1 reset_n_i = 1'b0;
    #1 check("async_reset", 32'(outs()), 32'd0);
    reset_load(3);
    cyc(1, 1, 0, 0, obs, od);

    // random traffic against the reference model
    reset_load(0);
    for (int i = 0; i < 4000; i++) begin
      bit rv; int r; logic [1:0] rt;
      if ($urandom_range(0, 199) == 0) reset_load($urandom_range(0, 8));
      if ($urandom_range(0, 2) != 0 && wptr - cptr < 8) wptr++;
      rv = ($urandom_range(0, 3) == 0);
      r  = $urandom_range(0, 99);
      rt = (r < 45) ? 2'd0 : (r < 85) ? 2'd1 : (r < 95) ? 2'd2 : 2'd3;
      cyc(1'b1, $urandom_range(0, 3) != 0, rv, rt, obs, od);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule

// File: doc/bsg_fifo_rolly_replay_tx.md
# bsg_fifo_rolly_replay_tx

Go-back-N link transmitter that drives the read side of a rollback FIFO (rolly FIFO) and forwards its words onto a lossy downstream link. Words sent on the link stay in the FIFO until the far end acknowledges them, either one word at a time or cumulatively. A nack or a response timeout rewinds the FIFO so that every unacknowledged word is re-sent. The block sits between a `bsg_fifo_1r1w_rolly`-family FIFO and a link serializer.

## Interface
Parameters:
- `width_p`, none: data word width.
- `lg_size_p`, none: log2 of the attached FIFO depth. Sizes all window and outstanding counters.
- `window_p`, `(1<<lg_size_p)`: maximum number of unacknowledged words in flight. Legal range is 1..2^lg_size_p.
- `timeout_p`, 64: number of response-free cycles with outstanding != 0 before an automatic rollback. Must be ≥ 1.
- `max_retries_p`, 8: number of consecutive rollbacks without progress before entering ERROR. Must be ≥ 1.

Ports:
- `clk_i` in 1: clock.
- `reset_n_i` in 1: reset. **One clock; reset is asynchronous and active-low.**
- `fifo_data_i` in `width_p`: FIFO read data.
- `fifo_v_i` in 1: FIFO valid.
- `fifo_yumi_o` out 1: dequeue strobe to the FIFO (advances its rptr).
- `fifo_incr_o` out 1: advance the FIFO read checkpoint by one word.
- `fifo_ack_o` out 1: advance the FIFO read checkpoint to its rptr.
- `fifo_rollback_o` out 1: reset the FIFO rptr to its checkpoint.
- `link_data_o` out `width_p`: word to the link. Equals `fifo_data_i`.
- `link_v_o` out 1: link valid.
- `link_ready_i` in 1: link ready.
- `resp_v_i` in 1: response valid. One response per cycle; a response is always consumed.
- `resp_type_i` in 2: response type. 2'b00 = single ack, 2'b01 = cumulative ack, 2'b10 = nack, 2'b11 = reserved (ignored; raises `proto_err_o`).
- `outstanding_o` out `lg_size_p+1`: current number of unacknowledged words.
- `error_o` out 1: sticky retry-exhaustion flag.
- `proto_err_o` out 1: single-cycle pulse on an illegal response.

## Operation
- State: `outstanding_r` (`lg_size_p+1` bits), `timer_r` (`$clog2(timeout_p+1)` bits), `retry_r` (`$clog2(max_retries_p+1)` bits), and a 2-state FSM with states SEND and ERROR.
- Send path in SEND:
  - `link_v_o` = `fifo_v_i & (outstanding_r < window_p) & ~fifo_rollback_o`.
  - `fifo_yumi_o` = `link_v_o & link_ready_i`.
- Link valid may drop without a handshake only in a rollback cycle. The link is go-back-N and tolerates this.
- Response decode in SEND, which drives at most one FIFO control per cycle:
  - Single ack with `outstanding_r > 0`: `fifo_incr_o` = 1.
  - Single ack with `outstanding_r == 0`: no FIFO action; `proto_err_o` = 1.
  - Cumulative ack: `fifo_ack_o` = 1. It is legal with `outstanding_r == 0` and is then a no-op in effect.
  - Nack: `fifo_rollback_o` = 1.
  - Timeout rollback: `fifo_rollback_o` = 1 when `resp_v_i` = 0, `outstanding_r` != 0 and `timer_r` == `timeout_p`.
  - A response arriving in the same cycle as a timeout takes priority; the timeout is not taken.
- `outstanding_r` next-state rules:
  - Rollback: 0.
  - Cumulative ack: `fifo_yumi_o ? 1 : 0`.
  - Otherwise: `outstanding_r + fifo_yumi_o - fifo_incr_o`.
- `timer_r`:
  - Clears on any `fifo_incr_o`, `fifo_ack_o` or `fifo_rollback_o`, and whenever `outstanding_r == 0`.
  - Otherwise increments, saturating at `timeout_p`.
- `retry_r`:
  - Clears on `fifo_incr_o` or `fifo_ack_o`.
  - Increments on `fifo_rollback_o`.
  - A rollback that makes the count reach `max_retries_p` moves the FSM to ERROR in the next cycle.
- ERROR state:
  - `link_v_o`, `fifo_yumi_o` and all FIFO controls are held at 0.
  - Responses are ignored.
  - `error_o` = 1 until reset.
- Invariants (bench asserts):
  - Never `fifo_ack_o` together with `fifo_incr_o` or `fifo_rollback_o`.
  - Never `fifo_incr_o` when `outstanding_r == 0`.
  - Never `fifo_yumi_o` together with `fifo_rollback_o`.
  - `outstanding_r <= window_p` always.

## Timing
- Reset (async assert, sync deassert at the FIFO): all outputs are 0, the FSM is in SEND, and all counters are 0.
- Send path is combinational from `fifo_v_i`/`link_ready_i` to `link_v_o`/`fifo_yumi_o`, with zero latency.
- Response-to-FIFO-control path is combinational, with zero latency. Counter effects appear the next cycle.
- After a rollback, `link_v_o` is 0 in the rollback cycle. The re-sent first word is offered on the following cycle, provided the FIFO presents it.
- Timeout fires in the cycle `timeout_p` consecutive cycles after the last progress or send-from-zero, not counting that cycle.
- Window full (`outstanding_r == window_p`): `link_v_o` = 0 until an incr, ack or rollback. A single ack at full allows a send in the next cycle.
- Reset asserted mid-burst: everything clears immediately. The FIFO is reset on the same reset.

## Test plan
- Window stall: `window_p` = 4, FIFO holds 6 words, link always ready, no responses → words 0-3 sent in 4 cycles, then `link_v_o` = 0 and `outstanding_o` = 4.
- Single ack at full: from the window-stall state, single ack → `fifo_incr_o` pulse, `outstanding_o` = 3, and word 4 is sent in the next cycle.
- Cumulative ack with send: `outstanding_o` = 3 plus a same-cycle yumi, cumulative ack → `fifo_ack_o` = 1 and `outstanding_o` = 1 next cycle.
- Nack rewind: nack with 3 outstanding → `fifo_rollback_o` = 1, `link_v_o` = 0 that cycle, the checkpointed word is re-sent next, and `outstanding_o` = 0 then 1.
- Timeout and retry exhaustion: `timeout_p` = 4, `max_retries_p` = 2, link delivers but no responses → rollback 4 cycles after the first send, again after the next timeout, then `error_o` = 1 and `link_v_o` held at 0.
- Protocol errors: single ack with 0 outstanding, and `resp_type_i` = 3 → `proto_err_o` pulses, no FIFO control is driven, and the counters are unchanged.
